player_sequencer: RTL and testbench

- Control unit for the music player datapath. It turns debounced user inputs (play, next, fast-forward and rewind switches) and song-reader status into a run/pause state, the current song index, player-reset pulses and a scaled note-advance strobe.
- It sits between the button/switch front end and the song reader / note player, and sequences every song change through a timed reset window.

---
 rtl/player_pkg.sv | 28 ++
 rtl/player_sequencer_beat_divider.sv | 36 +++
 rtl/player_sequencer.sv | 136 +++++++++++++
 tb/tb_player_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and defaults for the music player sequencer.
package player_pkg;

  localparam int NUM_SONGS_DEF = 4;
  localparam int SONG_BITS_DEF = 2;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FF     = 2'd1,
    REW    = 2'd2
  } mode_t;

  // Both switches high (or both low) is treated as normal playback.
  function automatic mode_t decode_mode(input logic ff_sw, input logic rew_sw);
    mode_t m;
    m = NORMAL;
    if (ff_sw && !rew_sw) m = FF;
    else if (rew_sw && !ff_sw) m = REW;
    return m;
  endfunction

endpackage

// File: rtl/player_sequencer_beat_divider.sv
// Beat tick divider: produces the pre-registered note-advance pulse.
// In bypass (fast-forward) every tick advances; otherwise every
// NORMAL_DIV-th tick does. A clear resets the count and swallows a
// coincident tick so a fresh count always starts from zero.
module beat_divider #(
  parameter int NORMAL_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  input  logic bypass,
  output logic pulse
);

  localparam int DW = $clog2(NORMAL_DIV);
  localparam logic [DW-1:0] LAST = DW'(NORMAL_DIV - 1);

  logic [DW-1:0] count;

  // Pulse on the tick that completes a full divide period (or any tick in bypass).
  always_comb begin
    pulse = 1'b0;
    if (tick && !clear) pulse = bypass || (count == LAST);
  end

  // Modulo tick counter; held at zero while bypassed or cleared.
  always_ff @(posedge clk) begin
    if (reset || clear || bypass) begin
      count <= '0;
    end else if (tick) begin
      count <= (count == LAST) ? '0 : count + DW'(1);
    end
  end

endmodule

// File: rtl/player_sequencer.sv
// Music player control unit: run/pause FSM, song index, timed player
// reset window on every song change, and the scaled note-advance strobe.
module player_sequencer
  import player_pkg::*;
#(
  parameter int NUM_SONGS    = NUM_SONGS_DEF,
  parameter int SONG_BITS    = SONG_BITS_DEF,
  parameter int RESET_CYCLES = 4,
  parameter int NORMAL_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_button,
  input  logic                 next_button,
  input  logic                 ff_switch0,
  input  logic                 r_switch1,
  input  logic                 beat_tick,
  input  logic                 song_done,
  input  logic                 at_start,
  output logic                 play,
  output logic                 reset_player,
  output logic [SONG_BITS-1:0] current_song,
  output logic                 advance,
  output logic                 reverse
);

  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RESET_CYCLES - 1);
  localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(NUM_SONGS - 1);

  state_t          state, next_state;
  logic            resume, next_resume;
  logic [CW-1:0]   cnt, next_cnt;
  logic            song_step;
  mode_t           mode, mode_q;
  logic            div_tick, div_clear, div_pulse;

  // Decode the playback mode from the switch levels every cycle.
  always_comb begin
    mode = decode_mode(ff_switch0, r_switch1);
  end

  // Next-state logic; next_button beats song_done beats play_button.
  always_comb begin
    next_state  = state;
    next_resume = resume;
    next_cnt    = cnt;
    song_step   = 1'b0;
    case (state)
      PAUSED: begin
        if (next_button) begin
          next_state  = CHANGE;
          next_resume = 1'b0;
          next_cnt    = CNT_LOAD;
          song_step   = 1'b1;
        end else if (play_button) begin
          next_state = PLAYING;
        end
      end
      PLAYING: begin
        if (next_button) begin
          next_state  = CHANGE;
          next_resume = 1'b1;
          next_cnt    = CNT_LOAD;
          song_step   = 1'b1;
        end else if (song_done) begin
          // Finishing the last song wraps to song 0 and stops the playlist.
          next_state  = CHANGE;
          next_resume = (current_song != LAST_SONG);
          next_cnt    = CNT_LOAD;
          song_step   = 1'b1;
        end else if (play_button) begin
          next_state = PAUSED;
        end else if (mode == REW && at_start) begin
          next_state = PAUSED;
        end
      end
      CHANGE: begin
        if (cnt == '0) begin
          next_state = resume ? PLAYING : PAUSED;
        end else begin
          next_cnt = cnt - CW'(1);
        end
      end
      default: begin
        next_state = PAUSED;
      end
    endcase
  end

  // Divider only sees ticks while playing, and restarts on any mode
  // change or when playback is about to stop.
  always_comb begin
    div_tick  = beat_tick && (state == PLAYING);
    div_clear = (state != PLAYING) || (next_state != PLAYING) || (mode != mode_q);
  end

  beat_divider #(
    .NORMAL_DIV(NORMAL_DIV)
  ) u_beat_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (div_tick),
    .clear (div_clear),
    .bypass(mode == FF),
    .pulse (div_pulse)
  );

  // State, counters, song index and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PAUSED;
      resume       <= 1'b0;
      cnt          <= '0;
      mode_q       <= NORMAL;
      current_song <= '0;
      play         <= 1'b0;
      reset_player <= 1'b0;
      advance      <= 1'b0;
      reverse      <= 1'b0;
    end else begin
      state        <= next_state;
      resume       <= next_resume;
      cnt          <= next_cnt;
      mode_q       <= mode;
      if (song_step) begin
        current_song <= (current_song == LAST_SONG) ? '0 : current_song + SONG_BITS'(1);
      end
      play         <= (next_state == PLAYING);
      reset_player <= (next_state == CHANGE);
      advance      <= div_pulse && (next_state == PLAYING);
      reverse      <= (next_state == PLAYING) && (mode == REW);
    end
  end

endmodule

// File: tb/tb_player_sequencer.sv
// Directed testbench for player_sequencer.
module tb_player_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_button = 1'b0;
  logic       next_button = 1'b0;
  logic       ff_switch0 = 1'b0;
  logic       r_switch1 = 1'b0;
  logic       beat_tick = 1'b0;
  logic       song_done = 1'b0;
  logic       at_start = 1'b0;
  logic       play;
  logic       reset_player;
  logic [1:0] current_song;
  logic       advance;
  logic       reverse;

  int tests = 0;
  int fails = 0;

  logic [3:0] mask;
  int         idle;

  player_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .play_button (play_button),
    .next_button (next_button),
    .ff_switch0  (ff_switch0),
    .r_switch1   (r_switch1),
    .beat_tick   (beat_tick),
    .song_done   (song_done),
    .at_start    (at_start),
    .play        (play),
    .reset_player(reset_player),
    .current_song(current_song),
    .advance     (advance),
    .reverse     (reverse)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue n ticks, each followed by an idle cycle; mask[i] is advance after tick i.
  task automatic run_ticks(input int n, output logic [3:0] m, output int idle_adv);
    m = '0;
    idle_adv = 0;
    for (int i = 0; i < n; i++) begin
      beat_tick = 1'b1;
      cyc(1);
      beat_tick = 1'b0;
      m[i] = advance;
      cyc(1);
      idle_adv += int'(advance);
    end
  endtask

  // Called right after the edge that started a song change.
  task automatic window(input logic [1:0] song, input logic play_after);
    chk("win_song", current_song, song);
    for (int i = 0; i < 4; i++) begin
      chk("win_rp", reset_player, 1'b1);
      chk("win_play", play, 1'b0);
      chk("win_adv", advance, 1'b0);
      beat_tick = (i < 3);
      cyc(1);
    end
    beat_tick = 1'b0;
    chk("win_rp_end", reset_player, 1'b0);
    chk("win_play_end", play, play_after);
    chk("win_song_end", current_song, song);
    chk("win_adv_end", advance, 1'b0);
  endtask

  task automatic pulse_play();
    play_button = 1'b1;
    cyc(1);
    play_button = 1'b0;
  endtask

  initial begin
    // Reset values
    reset = 1'b1;
    cyc(2);
    chk("rst_play", play, 1'b0);
    chk("rst_rp", reset_player, 1'b0);
    chk("rst_song", current_song, 2'd0);
    chk("rst_adv", advance, 1'b0);
    chk("rst_rev", reverse, 1'b0);
    reset = 1'b0;
    cyc(1);

    // Play, then normal-mode divide-by-2
    pulse_play();
    chk("play_on", play, 1'b1);
    chk("rev_normal", reverse, 1'b0);
    run_ticks(4, mask, idle);
    chk("normal_mask", mask, 4'b1010);
    chk("normal_idle", idle, 0);

    // Fast-forward: every tick advances
    ff_switch0 = 1'b1;
    cyc(1);
    run_ticks(4, mask, idle);
    chk("ff_mask", mask, 4'b1111);
    chk("ff_idle", idle, 0);
    chk("ff_rev", reverse, 1'b0);

    // Rewind: divide-by-2 with reverse set
    ff_switch0 = 1'b0;
    r_switch1 = 1'b1;
    cyc(1);
    chk("rew_rev", reverse, 1'b1);
    run_ticks(4, mask, idle);
    chk("rew_mask", mask, 4'b1010);
    chk("rew_idle", idle, 0);
    chk("rew_rev_hold", reverse, 1'b1);

    // Rewind hits start of song: pause, no further advances
    at_start = 1'b1;
    cyc(1);
    chk("atstart_play", play, 1'b0);
    chk("atstart_rev", reverse, 1'b0);
    run_ticks(2, mask, idle);
    chk("atstart_mask", mask, 4'b0000);
    chk("atstart_idle", idle, 0);
    at_start = 1'b0;
    r_switch1 = 1'b0;
    cyc(1);

    // song_done from song 0 while playing: song 1, resumes playing
    pulse_play();
    chk("play_again", play, 1'b1);
    song_done = 1'b1;
    cyc(1);
    song_done = 1'b0;
    window(2'd1, 1'b1);

    // next_button on song 1 while playing: song 2, resumes playing
    next_button = 1'b1;
    cyc(1);
    next_button = 1'b0;
    window(2'd2, 1'b1);

    // next_button on song 2: song 3
    next_button = 1'b1;
    cyc(1);
    next_button = 1'b0;
    window(2'd3, 1'b1);

    // song_done on the last song: wrap to 0 and stop
    song_done = 1'b1;
    cyc(1);
    song_done = 1'b0;
    window(2'd0, 1'b0);

    // Paused on song 0, next+play together: play toggle dropped
    next_button = 1'b1;
    play_button = 1'b1;
    cyc(1);
    next_button = 1'b0;
    play_button = 1'b0;
    window(2'd1, 1'b0);

    // Both switches high behaves as normal
    pulse_play();
    chk("both_play", play, 1'b1);
    ff_switch0 = 1'b1;
    r_switch1 = 1'b1;
    cyc(1);
    run_ticks(4, mask, idle);
    chk("both_mask", mask, 4'b1010);
    chk("both_idle", idle, 0);
    chk("both_rev", reverse, 1'b0);
    ff_switch0 = 1'b0;
    r_switch1 = 1'b0;
    cyc(1);

    // Reset during the second cycle of a change window
    next_button = 1'b1;
    cyc(1);
    next_button = 1'b0;
    chk("pre_rst_song", current_song, 2'd2);
    chk("pre_rst_rp", reset_player, 1'b1);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    chk("midrst_rp", reset_player, 1'b0);
    chk("midrst_song", current_song, 2'd0);
    chk("midrst_play", play, 1'b0);
    chk("midrst_adv", advance, 1'b0);
    reset = 1'b0;
    cyc(2);
    chk("post_rst_play", play, 1'b0);
    chk("post_rst_rp", reset_player, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
